// File: rtl/usb_arb_pkg.sv
// Shared types and constants for the two-port USB byte-channel arbiter.
package usb_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_DONE
    } arb_state_t;

    localparam logic [7:0] ARB_TIMEOUT_DATA = 8'hFF;

    // Width of a counter that must hold 0 .. limit-1.
    function automatic int timer_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/usb_arb_timer.sv
// Read-response watchdog: cleared before a wait, counts while enabled,
// flags the cycle in which it has counted TIMEOUT-1.
module usb_arb_timer
    import usb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = timer_width(TIMEOUT);

    logic [TW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == TW'(TIMEOUT - 1));

endmodule

// File: rtl/usb_port_arbiter.sv
// Round-robin merge of two byte read/write requesters onto one shared port,
// with a read-response timeout; all outputs are registered.
module usb_port_arbiter
    import usb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rd_req0,
    input  logic       rd_req1,
    input  logic       wr_req0,
    input  logic       wr_req1,
    input  logic [7:0] wd0,
    input  logic [7:0] wd1,
    output logic       drdy0,
    output logic       drdy1,
    output logic [7:0] d0,
    output logic [7:0] d1,
    output logic       wr_ack0,
    output logic       wr_ack1,
    output logic       timeout,
    output logic       rd,
    output logic       wr,
    output logic [7:0] wd,
    input  logic       drdy,
    input  logic [7:0] d
);

    arb_state_t state, state_n;
    logic       last, last_n;
    logic       gnt, gnt_n;
    logic       req0, req1, sel;
    logic       expired;

    logic       drdy0_n, drdy1_n, wr_ack0_n, wr_ack1_n, timeout_n, rd_n, wr_n;
    logic [7:0] d0_n, d1_n, wd_n;

    assign req0 = rd_req0 | wr_req0;
    assign req1 = rd_req1 | wr_req1;
    // On contention the port not served last wins.
    assign sel  = (req0 & req1) ? ~last : req1;

    usb_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state == ST_RD),
        .en      (state == ST_WAIT),
        .expired (expired)
    );

    // NOTE: every value written here gets a default first, so no latch is inferred.
    always_comb begin
        state_n   = state;
        last_n    = last;
        gnt_n     = gnt;
        drdy0_n   = 1'b0;
        drdy1_n   = 1'b0;
        wr_ack0_n = 1'b0;
        wr_ack1_n = 1'b0;
        timeout_n = 1'b0;
        rd_n      = 1'b0;
        wr_n      = 1'b0;
        d0_n      = d0;
        d1_n      = d1;
        wd_n      = wd;

        case (state)
            ST_IDLE: begin
                if (req0 | req1) begin
                    gnt_n = sel;
                    if (sel ? wr_req1 : wr_req0) begin
                        state_n   = ST_WR;
                        wr_n      = 1'b1;
                        wd_n      = sel ? wd1 : wd0;
                        wr_ack0_n = ~sel;
                        wr_ack1_n = sel;
                    end else begin
                        state_n = ST_RD;
                        rd_n    = 1'b1;
                    end
                end
            end
            ST_WR:   state_n = ST_DONE;
            ST_RD:   state_n = ST_WAIT;
            ST_WAIT: begin
                // A response in the final timeout cycle still counts as normal.
                if (drdy || expired) begin
                    state_n   = ST_DONE;
                    timeout_n = ~drdy;
                    drdy0_n   = ~gnt;
                    drdy1_n   = gnt;
                    if (gnt) d1_n = drdy ? d : ARB_TIMEOUT_DATA;
                    else     d0_n = drdy ? d : ARB_TIMEOUT_DATA;
                end
            end
            ST_DONE: begin
                last_n  = gnt;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            last    <= 1'b1;
            gnt     <= 1'b0;
            drdy0   <= 1'b0;
            drdy1   <= 1'b0;
            wr_ack0 <= 1'b0;
            wr_ack1 <= 1'b0;
            timeout <= 1'b0;
            rd      <= 1'b0;
            wr      <= 1'b0;
            d0      <= 8'h00;
            d1      <= 8'h00;
            wd      <= 8'h00;
        end else begin
            state   <= state_n;
            last    <= last_n;
            gnt     <= gnt_n;
            drdy0   <= drdy0_n;
            drdy1   <= drdy1_n;
            wr_ack0 <= wr_ack0_n;
            wr_ack1 <= wr_ack1_n;
            timeout <= timeout_n;
            rd      <= rd_n;
            wr      <= wr_n;
            d0      <= d0_n;
            d1      <= d1_n;
            wd      <= wd_n;
        end
    end

endmodule
